// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Data word returned to the requester when the watchdog aborts a transaction
  localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - saturating cycle counter that flags hung memory transactions
module mem_port_arbiter_watchdog #(
  parameter int TO_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic hit,
  output logic expired
);

  logic [TO_WIDTH-1:0] count;

  // Expiry is reported in the granted cycle where the counter sits at all-ones
  assign expired = active && (&count);

  // Count granted cycles without a memory response; restart on each new grant
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (active && !hit && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between i_cache refills and d_cache accesses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int TO_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic               i_ready,
  output logic [31:0]        i_dout,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  input  logic               d_rw,
  input  logic               d_strobe,
  output logic               d_ready,
  output logic [31:0]        d_dout,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  output logic               m_rw,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready,
  output logic               timeout_err
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       grant_i;
  logic       grant_d;
  logic       done;
  logic       wd_expired;
  logic       wd_active;

  assign wd_active = (state != ST_IDLE);

  mem_port_arbiter_watchdog #(
    .TO_WIDTH(TO_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_i || grant_d),
    .active (wd_active),
    .hit    (m_ready),
    .expired(wd_expired)
  );

  // Arbitration, completion detection and combinational ready/data return
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_dout    = 32'h0;
    d_dout    = 32'h0;
    case (state)
      ST_IDLE: begin
        // D wins a tie unless it had the previous grant
        if (d_strobe && (!i_strobe || last_grant == GRANT_I)) begin
          grant_d   = 1'b1;
          state_nxt = ST_GNT_D;
        end else if (i_strobe) begin
          grant_i   = 1'b1;
          state_nxt = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        done = m_ready || wd_expired;
        if (done) begin
          i_ready   = 1'b1;
          i_dout    = m_ready ? m_dout : TIMEOUT_DATA;
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT_D: begin
        done = m_ready || wd_expired;
        if (done) begin
          d_ready   = 1'b1;
          d_dout    = m_ready ? m_dout : TIMEOUT_DATA;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the granted request onto the memory port and track fairness and sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      m_a         <= '0;
      m_din       <= 32'h0;
      m_rw        <= 1'b0;
      m_strobe    <= 1'b0;
      last_grant  <= GRANT_I;
      timeout_err <= 1'b0;
    end else begin
      if (grant_d) begin
        m_a        <= d_a;
        m_din      <= d_din;
        m_rw       <= d_rw;
        m_strobe   <= 1'b1;
        last_grant <= GRANT_D;
      end else if (grant_i) begin
        m_a        <= i_a;
        m_din      <= 32'h0;
        m_rw       <= 1'b0;
        m_strobe   <= 1'b1;
        last_grant <= GRANT_I;
      end else if (done) begin
        m_strobe <= 1'b0;
      end
      // A real response in the saturation cycle counts as a normal completion
      if (done && !m_ready) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
